// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame size, FSM encoding and
// baud divider helper.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Clock cycles per bit; callers keep the result within 4..65535.
    function automatic int calc_bps_cnt(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_recv_if.sv
// Serial line in, received byte and status out.
// slave: the receiver itself; master: whatever drives the pin and consumes bytes.
interface uart_recv_if;
    import uart_pkg::*;

    logic                 uart_rxd;
    logic [DATA_BITS-1:0] uart_data;
    logic                 uart_done;
    logic                 uart_frame_err;
    logic                 uart_rx_busy;

    modport slave  (input  uart_rxd,
                    output uart_data, uart_done, uart_frame_err, uart_rx_busy);
    modport master (output uart_rxd,
                    input  uart_data, uart_done, uart_frame_err, uart_rx_busy);
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the async RX pin plus a falling-edge detector.
// All flops reset to 1 (idle line) so reset release never looks like a start bit.
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rxd_i,
    output logic rx_sync_o,
    output logic rx_negedge_o
);
    logic rx_s1_q, rx_s2_q, rx_s3_q;

    // Metastability chain, then one extra stage for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            rx_s1_q <= rxd_i;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
        end
    end

    assign rx_sync_o    = rx_s2_q;
    assign rx_negedge_o = rx_s3_q & ~rx_s2_q;
endmodule

// File: rtl/uart_recv.sv
// UART receiver, 8N1, LSB first. Samples at bit centres and reports each
// frame with a one-cycle done or frame-error pulse.
module uart_recv
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int UART_BPS = 9600
) (
    input logic       sys_clk,
    input logic       sys_rst_n,
    uart_recv_if.slave bus
);
    localparam int          BPS_CNT  = calc_bps_cnt(CLK_FREQ, UART_BPS);
    localparam logic [15:0] BIT_END  = 16'(BPS_CNT - 1);
    localparam logic [15:0] HALF_END = 16'(BPS_CNT / 2 - 1);
    localparam int          BCW      = $clog2(DATA_BITS + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

    logic rx_sync, rx_negedge;

    state_t               state_q,   state_d;
    logic [15:0]          clk_cnt_q, clk_cnt_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic [DATA_BITS-1:0] data_q,    data_d;
    logic                 done_q,    done_d;
    logic                 ferr_q,    ferr_d;

    uart_rx_sync u_sync (
        .clk_i        (sys_clk),
        .rst_ni       (sys_rst_n),
        .rxd_i        (bus.uart_rxd),
        .rx_sync_o    (rx_sync),
        .rx_negedge_o (rx_negedge)
    );

    // State, counters, shifter and output pulse registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
        end
    end

    // Next state: half-bit wait to validate the start bit, then full-bit
    // steps so every later sample lands mid-bit. STOP exits at its centre
    // so a back-to-back start edge is never missed.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + 16'd1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                clk_cnt_d = '0;
                if (rx_negedge) state_d = ST_START;
            end
            ST_START: begin
                if (clk_cnt_q == HALF_END) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    // A high line at mid-start was only a glitch.
                    state_d   = rx_sync ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (clk_cnt_q == BIT_END) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_sync, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (clk_cnt_q == BIT_END) begin
                    clk_cnt_d = '0;
                    state_d   = ST_IDLE;
                    if (rx_sync) begin
                        data_d = shift_q;
                        done_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.uart_data      = data_q;
    assign bus.uart_done      = done_q;
    assign bus.uart_frame_err = ferr_q;
    assign bus.uart_rx_busy   = (state_q != ST_IDLE);
endmodule
